// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter.
//
// This block sends one command byte to a PS/2 device, such as 0xED (set
// LEDs), 0xF4 (enable) or 0xFF (reset). It shares the ps2_clk and
// ps2_data pins with the receive path through open-drain pull-low enables.
//
// Frame sequence:
//   1. Inhibit: hold ps2_clk low.
//   2. Start: pull data low, then release the clock.
//   3. On each device falling edge, shift out 8 data bits (LSB first),
//      then odd parity, then a released stop bit.
//   4. Sample the device acknowledge on the 11th falling edge.
//   5. Wait for the bus to go idle, then report done.
//
// Optional build macro PS2_TX_TIMEOUT_EN adds a watchdog. It counts from
// clock release until the acknowledge. When it expires, it aborts the
// frame with tx_error.
//
// Ports:
//   clk                 system clock, rising edge
//   reset               asynchronous, active-low reset
//   tx_data[7:0]        command byte
//   tx_valid            request to send tx_data (accepted only when tx_ready)
//   tx_ready            high only while idle
//   busy                high while a frame is in progress
//   tx_done             one-cycle pulse: byte sent and acknowledged
//   tx_error            one-cycle pulse: NACK, or watchdog timeout
//   ps2_clk_in          raw PS/2 clock pin level
//   ps2_data_in         raw PS/2 data pin level
//   ps2_clk_drive_low   1 = pull ps2_clk low, 0 = release
//   ps2_data_drive_low  1 = pull ps2_data low, 0 = release
//
// Handshake: a request transfers on a rising clk edge where tx_valid and
// tx_ready are both high. tx_data is captured on that edge. tx_valid is
// ignored at all other times.
module ps2_host_tx #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int INHIBIT_US  = 100,
  parameter int TIMEOUT_US  = 15000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low
);

  // Cycles per microsecond first, so the product stays inside 32 bits.
  localparam int INHIBIT_CYCLES = (CLK_FREQ_HZ / 1000000) * INHIBIT_US;
  localparam int TIMEOUT_CYCLES = (CLK_FREQ_HZ / 1000000) * TIMEOUT_US;
  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_SEND, S_ACK, S_RELEASE
  } state_t;

  state_t           r_state, w_state_n;
  logic             r_clk_s1, r_clk_s2, r_clk_prev;
  logic             r_data_s1, r_data_s2;
  logic [8:0]       r_shift, w_shift_n;      // {parity, data}, shifted out LSB first
  logic [3:0]       r_bit_idx, w_bit_idx_n;  // falling edges seen in this frame
  logic             r_data_low, w_data_low_n;
  logic [INH_W-1:0] r_inh_cnt, w_inh_cnt_n;
  logic             w_fall;
  logic             w_to_hit;
  logic             w_tx_done, w_tx_error;

  assign w_fall = r_clk_prev & ~r_clk_s2;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] r_to_cnt;

  assign w_to_hit = ((r_state == S_SEND) || (r_state == S_ACK)) &&
                    (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_to_cnt <= '0;
    end else if (r_state == S_START) begin
      r_to_cnt <= '0;
    end else if (((r_state == S_SEND) || (r_state == S_ACK)) && !w_to_hit) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  // No watchdog: the frame waits for device clocks indefinitely. The term
  // below is constant false; it keeps TIMEOUT_CYCLES referenced so both
  // builds share one parameter list.
  assign w_to_hit = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_data_s1  <= 1'b1;
      r_data_s2  <= 1'b1;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_data_low <= 1'b0;
      r_inh_cnt  <= '0;
    end else begin
      r_clk_s1   <= ps2_clk_in;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_data_s1  <= ps2_data_in;
      r_data_s2  <= r_data_s1;
      r_state    <= w_state_n;
      r_shift    <= w_shift_n;
      r_bit_idx  <= w_bit_idx_n;
      r_data_low <= w_data_low_n;
      r_inh_cnt  <= w_inh_cnt_n;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_shift_n    = r_shift;
    w_bit_idx_n  = r_bit_idx;
    w_data_low_n = r_data_low;
    w_inh_cnt_n  = r_inh_cnt;
    w_tx_done    = 1'b0;
    w_tx_error   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (tx_valid) begin
          w_shift_n   = {~^tx_data, tx_data};
          w_inh_cnt_n = '0;
          w_bit_idx_n = '0;
          w_state_n   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
          w_state_n = S_START;
        end else begin
          w_inh_cnt_n = r_inh_cnt + 1'b1;
        end
      end
      S_START: begin
        // The start bit (data low) stays driven until the first device edge.
        w_data_low_n = 1'b1;
        w_bit_idx_n  = '0;
        w_state_n    = S_SEND;
      end
      S_SEND: begin
        if (w_to_hit) begin
          w_tx_error = 1'b1;
          w_state_n  = S_IDLE;
        end else if (w_fall) begin
          w_bit_idx_n = r_bit_idx + 4'd1;
          if (r_bit_idx < 4'd9) begin
            // Edges 1..9: data bits then parity; drive low to send a 0.
            w_data_low_n = ~r_shift[0];
            w_shift_n    = {1'b0, r_shift[8:1]};
          end else begin
            // Edge 10: release the line so the stop bit reads as 1.
            w_data_low_n = 1'b0;
            w_state_n    = S_ACK;
          end
        end
      end
      S_ACK: begin
        if (w_to_hit) begin
          w_tx_error = 1'b1;
          w_state_n  = S_IDLE;
        end else if (w_fall) begin
          w_bit_idx_n = 4'd11;
          if (!r_data_s2) begin
            w_state_n = S_RELEASE;
          end else begin
            w_tx_error = 1'b1;
            w_state_n  = S_IDLE;
          end
        end
      end
      S_RELEASE: begin
        if (r_clk_s2 && r_data_s2) begin
          w_tx_done = 1'b1;
          w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Pin drives decode the registered state, so an asynchronous reset
  // releases the bus immediately, even mid-frame.
  assign tx_ready           = (r_state == S_IDLE);
  assign busy               = (r_state != S_IDLE);
  assign ps2_clk_drive_low  = (r_state == S_INHIBIT) || (r_state == S_START);
  assign ps2_data_drive_low = (r_state == S_START) || ((r_state == S_SEND) && r_data_low);
  assign tx_done            = w_tx_done;
  assign tx_error           = w_tx_error;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends command bytes to the keyboard, e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset.
- Opposite direction of the existing PS/2 receive path. Shares the same ps2_clk/ps2_data pins through open-drain enables.
- Runs the full host request sequence: clock inhibit, start, 8 data bits, odd parity, stop, then samples the device acknowledge.

Parameters:
- CLK_FREQ_HZ, 50000000, system clock frequency.
- INHIBIT_US, 100, time ps2_clk is held low before the start bit.
- TIMEOUT_US, 15000, watchdog limit from clock release to ack (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- tx_data  in  8  command byte.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  high only in IDLE.
- busy  out  1  high in any state other than IDLE.
- tx_done  out  1  one-cycle pulse: byte sent and acknowledged.
- tx_error  out  1  one-cycle pulse: NACK, or timeout (with feature).
- ps2_clk_in  in  1  raw PS/2 clock pin level.
- ps2_data_in  in  1  raw PS/2 data pin level.
- ps2_clk_drive_low  out  1  1 = pull ps2_clk low, 0 = release.
- ps2_data_drive_low  out  1  1 = pull ps2_data low, 0 = release.

Behaviour:
- Reset (reset=0, async):
  - State IDLE; all outputs 0 except tx_ready=1.
  - Both drive_low outputs clear immediately, releasing the bus, even mid-frame.
  - Sync flops cleared to 1.
- Input sync: ps2_clk_in and ps2_data_in each pass through a 2-flop synchronizer.
- Falling edge of the synchronized clock: previous=1 and current=0.
- Pin-to-drive latency: 3 clk cycles from pin fall to drive update.
- Accept: on tx_valid && tx_ready, latch tx_data and compute parity = ~^tx_data (odd parity), then go to INHIBIT. tx_valid is ignored while busy.
- States:
  - INHIBIT: clk_drive_low=1 for INHIBIT_US*CLK_FREQ_HZ/1e6 cycles (5000 at defaults).
  - START: data_drive_low=1 with clk_drive_low=1 for 1 cycle. Then clk_drive_low=0 and go to SEND, bit index 0.
  - SEND: on each falling edge, bit index k=1..8 drives data[k-1], LSB first; k=9 drives parity; k=10 releases data (stop=1). "Drive bit b" means data_drive_low = ~b.
  - ACK: on the 11th falling edge, sample synchronized data. 0 = ack, go to RELEASE. 1 = NACK, pulse tx_error and go to IDLE.
  - RELEASE: wait until synchronized clk=1 and data=1, pulse tx_done, go to IDLE.
- Bit counter is 4 bits and never wraps past 11.
- tx_done and tx_error are never asserted in the same cycle.
- Device activity seen in IDLE is ignored; no drive outputs change.

Optional Feature:
- Macro: PS2_TX_TIMEOUT_EN.
- With it: a counter starts at the end of START and counts until ACK is reached.
  - Exceeding TIMEOUT_US*CLK_FREQ_HZ/1e6 cycles releases both lines, pulses tx_error, and returns to IDLE.
  - The counter is sized with $clog2 of that limit.
- Without it: no counter is present; the block waits indefinitely for device clocks.

Test Plan:
- Send 0xED with the device model ack → clk held low exactly 5000 cycles; data bits on successive falling edges are 1,0,1,1,0,1,1,1; parity=1; stop released; tx_done pulses once; tx_ready returns to 1.
- Send 0xF4 → data bits 0,0,1,0,1,1,1,1, parity=0, tx_done pulse.
- Device leaves data high on the 11th edge (NACK) → tx_error pulse, no tx_done, both lines released.
- Assert reset low during SEND bit 4 → drive outputs 0 within the same cycle; after reset release, tx_ready=1, and a new 0xFF transfer completes normally.
- tx_valid pulsed with 0x00 while busy sending 0xED → ignored; only 0xED appears on the bus.
- With PS2_TX_TIMEOUT_EN: device never clocks → tx_error after 750000 cycles (15 ms at 50 MHz), bus released. Without the macro → block stays busy.
